// File: rtl/pixel_lut_xform_if.sv
// Pixel stream, table configuration and status bundle for pixel_lut_xform.
interface pixel_lut_xform_if #(
    parameter int unsigned DW = 8
);
    logic          i_hsync;
    logic          i_vsync;
    logic          i_blank;
    logic [DW-1:0] i_pix;
    logic [1:0]    i_mode;
    logic          cfg_we;
    logic [DW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          cfg_swap;
    logic          o_swap_pend;
    logic          o_ready;
    logic          o_hsync;
    logic          o_vsync;
    logic          o_blank;
    logic [DW-1:0] o_y;
    logic [15:0]   o_rgb565;

    // Upstream side: drives video and config, observes results.
    modport master (
        output i_hsync, i_vsync, i_blank, i_pix, i_mode,
        output cfg_we, cfg_addr, cfg_data, cfg_swap,
        input  o_swap_pend, o_ready, o_hsync, o_vsync, o_blank, o_y, o_rgb565
    );

    // Transform stage side.
    modport slave (
        input  i_hsync, i_vsync, i_blank, i_pix, i_mode,
        input  cfg_we, cfg_addr, cfg_data, cfg_swap,
        output o_swap_pend, o_ready, o_hsync, o_vsync, o_blank, o_y, o_rgb565
    );
endinterface

// File: rtl/pixel_lut_xform.sv
// Luma point-operation stage: double-buffered LUT with bypass/invert modes,
// bank swap only at frame start, syncs delayed to match the 2-cycle data path.
module pixel_lut_xform #(
    parameter int unsigned DW        = 8,
    parameter bit          VS_ACTIVE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    pixel_lut_xform_if.slave bus
);
    localparam int unsigned   DEPTH     = 1 << DW;
    localparam logic [DW-1:0] LAST_ADDR = DW'(DEPTH - 1);
    localparam logic          VS_IDLE   = ~VS_ACTIVE;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] init_cnt_q, init_cnt_d;
    logic          bank_q, bank_d;
    logic          pend_q, pend_d;
    logic          ready_q, ready_d;
    logic [1:0]    mode_q, mode_d;

    logic [DW-1:0] pix1_q, pix1_d;
    logic [DW-1:0] tbl1_q, tbl1_d;
    logic          hs1_q, hs1_d;
    logic          vs1_q, vs1_d;
    logic          bl1_q, bl1_d;
    logic          run1_q, run1_d;

    logic          hs2_q, hs2_d;
    logic          vs2_q, vs2_d;
    logic          bl2_q, bl2_d;
    logic [DW-1:0] y2_q, y2_d;
    logic [15:0]   rgb2_q, rgb2_d;

    logic          frame_start_c;
    logic          init_wr_c;
    logic          cfg_wr_c;
    logic [1:0]    eff_mode_c;
    logic [DW-1:0] y_sel_c;

    logic [DW-1:0] mem [2][DEPTH];

    // Frame start: registered vsync has just entered the active level.
    assign frame_start_c = (vs1_q == VS_ACTIVE) && (vs2_q != VS_ACTIVE);

    // Control FSM, bank select, swap request and mode capture.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        bank_d     = bank_q;
        pend_d     = pend_q;
        mode_d     = mode_q;
        init_wr_c  = 1'b0;
        cfg_wr_c   = 1'b0;
        ready_d    = (state_q == ST_RUN);

        if (frame_start_c) begin
            mode_d = bus.i_mode;
        end

        case (state_q)
            ST_INIT: begin
                init_wr_c  = 1'b1;
                init_cnt_d = init_cnt_q + DW'(1);
                if (init_cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cfg_wr_c = bus.cfg_we;
                if (frame_start_c) begin
                    if (pend_q) begin
                        bank_d = ~bank_q;
                    end
                    // a request in the swap cycle itself waits for the next frame
                    pend_d = bus.cfg_swap;
                end else if (bus.cfg_swap) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Pixel pipeline: stage 1 table read, stage 2 mode select and blanking.
    always_comb begin
        pix1_d = bus.i_pix;
        tbl1_d = mem[bank_q][bus.i_pix];
        hs1_d  = bus.i_hsync;
        vs1_d  = bus.i_vsync;
        bl1_d  = bus.i_blank;
        run1_d = (state_q == ST_RUN);

        eff_mode_c = run1_q ? mode_q : 2'b00;
        case (eff_mode_c)
            2'b01:   y_sel_c = tbl1_q;
            2'b10:   y_sel_c = ~pix1_q;
            2'b11:   y_sel_c = ~tbl1_q;
            default: y_sel_c = pix1_q;
        endcase

        hs2_d  = hs1_q;
        vs2_d  = vs1_q;
        bl2_d  = bl1_q;
        y2_d   = bl1_q ? '0 : y_sel_c;
        rgb2_d = {y2_d[DW-1-:5], y2_d[DW-1-:6], y2_d[DW-1-:5]};
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            bank_q     <= 1'b0;
            pend_q     <= 1'b0;
            ready_q    <= 1'b0;
            mode_q     <= 2'b00;
            pix1_q     <= '0;
            tbl1_q     <= '0;
            hs1_q      <= 1'b0;
            vs1_q      <= VS_IDLE;
            bl1_q      <= 1'b0;
            run1_q     <= 1'b0;
            hs2_q      <= 1'b0;
            vs2_q      <= VS_IDLE;
            bl2_q      <= 1'b0;
            y2_q       <= '0;
            rgb2_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            bank_q     <= bank_d;
            pend_q     <= pend_d;
            ready_q    <= ready_d;
            mode_q     <= mode_d;
            pix1_q     <= pix1_d;
            tbl1_q     <= tbl1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            bl1_q      <= bl1_d;
            run1_q     <= run1_d;
            hs2_q      <= hs2_d;
            vs2_q      <= vs2_d;
            bl2_q      <= bl2_d;
            y2_q       <= y2_d;
            rgb2_q     <= rgb2_d;
        end
    end

    // Table banks: identity fill on init, otherwise shadow-bank writes only.
    always_ff @(posedge clk) begin
        if (init_wr_c) begin
            mem[0][init_cnt_q] <= init_cnt_q;
            mem[1][init_cnt_q] <= init_cnt_q;
        end else if (cfg_wr_c) begin
            mem[~bank_q][bus.cfg_addr] <= bus.cfg_data;
        end
    end

    assign bus.o_swap_pend = pend_q;
    assign bus.o_ready     = ready_q;
    assign bus.o_hsync     = hs2_q;
    assign bus.o_vsync     = vs2_q;
    assign bus.o_blank     = bl2_q;
    assign bus.o_y         = y2_q;
    assign bus.o_rgb565    = rgb2_q;
endmodule

// File: tb/tb_pixel_lut_xform.sv
// Self-checking bench for pixel_lut_xform (DW=8, VS_ACTIVE=1).
module tb_pixel_lut_xform;
    localparam int unsigned DW  = 8;
    localparam int unsigned N   = 256;
    localparam logic        VSA = 1'b1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pixel_lut_xform_if #(.DW(DW)) bus ();
    pixel_lut_xform #(.DW(DW), .VS_ACTIVE(VSA)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: both table banks, active bank, pending swap.
    logic [7:0] tbl_m [2][N];
    int         act_m;
    logic       pend_m;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] pix;
        logic       blank;
        logic [7:0] exp_y;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] rgb_of(input logic [7:0] y);
        return {y[7:3], y[7:2], y[7:3]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int a = 0; a < N; a++) begin
            tbl_m[0][a] = 8'(a);
            tbl_m[1][a] = 8'(a);
        end
        act_m  = 0;
        pend_m = 1'b0;
    endtask

    // Blanked vsync pulse; the new mode and any pending swap take effect.
    task automatic frame_start(input logic [1:0] mode);
        bus.i_blank = 1'b1;
        bus.i_mode  = mode;
        bus.i_vsync = ~VSA;
        repeat (2) cyc();
        bus.i_vsync = VSA;
        repeat (3) cyc();
        bus.i_vsync = ~VSA;
        repeat (3) cyc();
        if (pend_m) begin
            act_m  = 1 - act_m;
            pend_m = 1'b0;
        end
    endtask

    // kind: 0 identity, 1 reverse (255-a), 2 random
    task automatic load_shadow(input int kind);
        logic [7:0] d;
        for (int a = 0; a < N; a++) begin
            d = (kind == 1) ? 8'(255 - a) : (kind == 2) ? 8'($urandom_range(0, 255)) : 8'(a);
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = 8'(a);
            bus.cfg_data = d;
            tbl_m[1 - act_m][a] = d;
            cyc();
        end
        bus.cfg_we = 1'b0;
    endtask

    task automatic swap_req();
        bus.cfg_swap = 1'b1;
        cyc();
        bus.cfg_swap = 1'b0;
        pend_m = 1'b1;
    endtask

    task automatic pix_check(input string name, input logic [7:0] p, input logic [7:0] exp);
        bus.i_blank = 1'b0;
        bus.i_pix   = p;
        cyc();
        cyc();
        check(name, 32'(bus.o_y), 32'(exp));
        check({name, "_rgb"}, 32'(bus.o_rgb565), 32'(rgb_of(exp)));
    endtask

    initial begin
        int         cnt;
        logic [2:0] prev_sync;
        logic [7:0] prev_y;
        logic       hs, vs, bl;
        logic [7:0] p;

        vecs[0] = '{2'b01, 8'h10, 1'b0, 8'hEF};
        vecs[1] = '{2'b01, 8'h00, 1'b0, 8'hFF};
        vecs[2] = '{2'b11, 8'h10, 1'b0, 8'h10};
        vecs[3] = '{2'b11, 8'hC3, 1'b0, 8'hC3};
        vecs[4] = '{2'b10, 8'h00, 1'b0, 8'hFF};
        vecs[5] = '{2'b10, 8'hA5, 1'b0, 8'h5A};
        vecs[6] = '{2'b00, 8'h37, 1'b0, 8'h37};
        vecs[7] = '{2'b00, 8'h80, 1'b1, 8'h00};
        vecs[8] = '{2'b01, 8'h80, 1'b1, 8'h00};
        vecs[9] = '{2'b11, 8'h00, 1'b0, 8'h00};

        bus.i_hsync  = 1'b0;
        bus.i_vsync  = ~VSA;
        bus.i_blank  = 1'b0;
        bus.i_pix    = 8'h00;
        bus.i_mode   = 2'b00;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = 8'h00;
        bus.cfg_data = 8'h00;
        bus.cfg_swap = 1'b0;
        model_reset();

        // Reset state
        repeat (3) cyc();
        check("rst_sync", 32'({bus.o_hsync, bus.o_vsync, bus.o_blank}), 32'({1'b0, ~VSA, 1'b0}));
        check("rst_y", 32'(bus.o_y), 32'h0);
        check("rst_rgb", 32'(bus.o_rgb565), 32'h0);
        check("rst_ready", 32'(bus.o_ready), 32'h0);
        check("rst_pend", 32'(bus.o_swap_pend), 32'h0);

        // INIT latency, with config writes and swap requests that must be ignored
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 8'h33;
        bus.cfg_data = 8'h00;
        bus.cfg_swap = 1'b1;
        rst_n = 1'b1;
        for (cnt = 1; cnt <= 400; cnt++) begin
            cyc();
            if (cnt == 200) begin
                bus.cfg_we   = 1'b0;
                bus.cfg_swap = 1'b0;
            end
            if (bus.o_ready) break;
        end
        check("ready_latency", 32'(cnt), 32'd257);
        check("init_pend_ignored", 32'(bus.o_swap_pend), 32'h0);
        frame_start(2'b01);
        pix_check("lut_identity_5a", 8'h5A, 8'h5A);
        pix_check("init_we_ignored", 8'h33, 8'h33);

        // Shadow load + mid-frame swap request
        load_shadow(1);
        swap_req();
        check("pend_set", 32'(bus.o_swap_pend), 32'h1);
        pix_check("pre_swap_identity", 8'h10, 8'h10);
        swap_req();
        check("pend_still_set", 32'(bus.o_swap_pend), 32'h1);
        frame_start(2'b01);
        check("pend_cleared", 32'(bus.o_swap_pend), 32'h0);
        pix_check("post_swap_lut", 8'h10, 8'hEF);

        // Mode vectors against the reverse table
        for (int i = 0; i < 10; i++) begin
            frame_start(vecs[i].mode);
            bus.i_blank = vecs[i].blank;
            bus.i_pix   = vecs[i].pix;
            cyc();
            cyc();
            check($sformatf("vec%0d_y", i), 32'(bus.o_y), 32'(vecs[i].exp_y));
            check($sformatf("vec%0d_rgb", i), 32'(bus.o_rgb565), 32'(rgb_of(vecs[i].exp_y)));
        end

        // Mode change mid-frame waits for the next frame start
        frame_start(2'b10);
        bus.i_mode = 2'b00;
        pix_check("mode_mid_frame", 8'h05, 8'hFA);
        frame_start(2'b00);
        pix_check("mode_next_frame", 8'h05, 8'h05);

        // Random table, random syncs/blank/pixels in LUT mode
        load_shadow(2);
        swap_req();
        frame_start(2'b01);
        prev_sync = 3'b000;
        prev_y    = 8'h00;
        for (int i = 0; i < 300; i++) begin
            hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
            bl = 1'($urandom_range(0, 1));
            p  = 8'($urandom_range(0, 255));
            bus.i_hsync = hs;
            bus.i_vsync = vs;
            bus.i_blank = bl;
            bus.i_pix   = p;
            cyc();
            if (i > 0) begin
                check("rnd_sync", 32'({bus.o_hsync, bus.o_vsync, bus.o_blank}), 32'(prev_sync));
                check("rnd_y", 32'(bus.o_y), 32'(prev_y));
                check("rnd_rgb", 32'(bus.o_rgb565), 32'(rgb_of(prev_y)));
                if (bus.o_blank) check("rnd_blank_y0", 32'(bus.o_y), 32'h0);
            end
            prev_sync = {hs, vs, bl};
            prev_y    = bl ? 8'h00 : tbl_m[act_m][p];
        end
        bus.i_hsync = 1'b0;

        // Swap request in the exact frame-start cycle
        p = 8'h21;
        for (int k = 0; k < N; k++) begin
            if (tbl_m[act_m][p] != tbl_m[1 - act_m][p]) break;
            p = p + 8'd1;
        end
        bus.i_vsync = ~VSA;
        bus.i_blank = 1'b1;
        repeat (3) cyc();
        bus.i_vsync = VSA;
        cyc();
        bus.cfg_swap = 1'b1;
        cyc();
        bus.cfg_swap = 1'b0;
        pend_m = 1'b1;
        repeat (2) cyc();
        bus.i_vsync = ~VSA;
        repeat (3) cyc();
        check("fs_cycle_swap_pend", 32'(bus.o_swap_pend), 32'(pend_m));
        pix_check("fs_cycle_not_taken", p, tbl_m[act_m][p]);
        frame_start(2'b01);
        check("fs_cycle_pend_clear", 32'(bus.o_swap_pend), 32'h0);
        pix_check("fs_cycle_taken_next", p, tbl_m[act_m][p]);

        // Reset while a swap is pending with a custom table active
        swap_req();
        check("pre_rst_pend", 32'(bus.o_swap_pend), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pend", 32'(bus.o_swap_pend), 32'h0);
        check("async_rst_ready", 32'(bus.o_ready), 32'h0);
        cyc();
        rst_n = 1'b1;
        model_reset();
        repeat (10) cyc();
        check("reinit_ready", 32'(bus.o_ready), 32'h0);
        check("reinit_pend", 32'(bus.o_swap_pend), 32'h0);
        for (cnt = 11; cnt <= 400; cnt++) begin
            cyc();
            if (bus.o_ready) break;
        end
        check("reinit_latency", 32'(cnt), 32'd257);
        frame_start(2'b01);
        pix_check("reinit_identity_10", 8'h10, 8'h10);
        pix_check("reinit_identity_c3", 8'hC3, 8'hC3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
